// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_pkg
//  Purpose  : Shared types and select codes for the ID-stage hazard unit.
//  Revision : 1.0 - initial release
// ============================================================================
package hazard_pkg;

  // Widest register address a stage entry can hold. Narrower designs store
  // the address zero-extended and compare only the low REG_AW bits.
  localparam int MAX_REG_AW = 8;

  // Operand select: 0 reads the register file.
  localparam int SEL_RF = 0;

  // Operand select for the multi-cycle result bus, one past the last stage.
  function automatic int sel_mc(input int depth);
    return depth + 1;
  endfunction

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mc_state_t;

  typedef struct packed {
    logic                  valid;
    logic [MAX_REG_AW-1:0] dest;
    logic                  we;
    logic                  is_load;
  } stage_t;

endpackage
`default_nettype wire

// File: rtl/hazard_forward_unit_src_match.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_src_match
//  Purpose  : Priority match of one source operand against the in-flight
//             destination tags; yields its forwarding select and whether the
//             winning producer is a load that is not ready yet.
//  Revision : 1.0 - initial release
// ============================================================================
module hazard_src_match
  import hazard_pkg::*;
#(
  parameter int REG_AW     = 5,
  parameter int DEPTH      = 3,
  parameter int LOAD_READY = 2,
  parameter int SEL_W      = 3
) (
  input  logic [REG_AW-1:0]       src,
  input  logic                    used,
  input  logic [DEPTH-1:0]        stg_valid,
  input  logic [DEPTH-1:0]        stg_we,
  input  logic [DEPTH-1:0]        stg_load,
  input  logic [DEPTH*REG_AW-1:0] stg_dest,
  input  logic                    mc_avail,
  input  logic [REG_AW-1:0]       mc_dest,
  output logic [SEL_W-1:0]        sel,
  output logic                    load_use,
  output logic                    mc_match
);

  logic             w_live;
  logic [DEPTH-1:0] w_hit;

  // $0 is hard-wired zero, so it never depends on anything.
  assign w_live   = used && (src != '0);
  assign mc_match = w_live && (src == mc_dest);

  generate
    for (genvar s = 0; s < DEPTH; s++) begin : g_stage
      assign w_hit[s] = w_live && stg_valid[s] && stg_we[s] &&
                        (stg_dest[s*REG_AW +: REG_AW] == src);
    end
  endgenerate

  // Oldest-to-youngest scan so the youngest matching stage overrides the rest.
  always_comb begin
    sel      = SEL_W'(SEL_RF);
    load_use = 1'b0;
    if (mc_avail && mc_match) begin
      sel = SEL_W'(sel_mc(DEPTH));
    end
    for (int s = DEPTH - 1; s >= 0; s--) begin
      if (w_hit[s]) begin
        sel      = SEL_W'(s + 1);
        load_use = stg_load[s] && ((s + 1) < LOAD_READY);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/hazard_forward_unit.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_forward_unit
//  Purpose  : ID-stage hazard unit: tracks in-flight destinations, produces
//             per-source forwarding selects, load-use and multi-cycle stalls.
//  Revision : 1.0 - initial release
// ============================================================================
module hazard_forward_unit
  import hazard_pkg::*;
#(
  parameter int REG_AW     = 5,
  parameter int NUM_SRC    = 2,
  parameter int DEPTH      = 3,
  parameter int LOAD_READY = 2,
  parameter int MC_LAT     = 4,
  parameter int SEL_W      = $clog2(DEPTH + 2)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      id_valid,
  input  logic [NUM_SRC*REG_AW-1:0] id_src,
  input  logic [NUM_SRC-1:0]        id_src_used,
  input  logic [REG_AW-1:0]         id_dest,
  input  logic                      id_we,
  input  logic                      id_is_load,
  input  logic                      id_is_mc,
  input  logic                      mem_wait,
  input  logic                      flush,
  output logic                      stall,
  output logic                      bubble,
  output logic [NUM_SRC*SEL_W-1:0]  fwd_sel,
  output logic [NUM_SRC-1:0]        hazard,
  output logic                      mc_busy,
  output logic                      mc_done
);

  // Counter holds MC_LAT-1 down to 0.
  localparam int CNT_W = (MC_LAT > 2) ? $clog2(MC_LAT) : 1;

  stage_t                  r_stage [DEPTH];
  stage_t                  w_new;
  mc_state_t               r_state, w_state_nx;
  logic [CNT_W-1:0]        r_cnt, w_cnt_nx;
  logic [REG_AW-1:0]       r_mc_dest, w_mc_dest_nx;
  logic [DEPTH-1:0]        w_stg_valid, w_stg_we, w_stg_load;
  logic [DEPTH*REG_AW-1:0] w_stg_dest;
  logic [NUM_SRC-1:0]      w_load_use, w_mc_match;
  logic                    w_busy, w_done, w_issue, w_haz_stall;

  assign w_busy = (r_state == BUSY);
  assign w_done = (r_state == DONE);

  generate
    for (genvar s = 0; s < DEPTH; s++) begin : g_tags
      assign w_stg_valid[s]                  = r_stage[s].valid;
      assign w_stg_we[s]                     = r_stage[s].we;
      assign w_stg_load[s]                   = r_stage[s].is_load;
      assign w_stg_dest[s*REG_AW +: REG_AW]  = r_stage[s].dest[REG_AW-1:0];
    end

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
      hazard_src_match #(
        .REG_AW     (REG_AW),
        .DEPTH      (DEPTH),
        .LOAD_READY (LOAD_READY),
        .SEL_W      (SEL_W)
      ) u_match (
        .src       (id_src[i*REG_AW +: REG_AW]),
        .used      (id_src_used[i]),
        .stg_valid (w_stg_valid),
        .stg_we    (w_stg_we),
        .stg_load  (w_stg_load),
        .stg_dest  (w_stg_dest),
        .mc_avail  (w_done),
        .mc_dest   (r_mc_dest),
        .sel       (fwd_sel[i*SEL_W +: SEL_W]),
        .load_use  (w_load_use[i]),
        .mc_match  (w_mc_match[i])
      );
      assign hazard[i] = |fwd_sel[i*SEL_W +: SEL_W];
    end
  endgenerate

  // Hazard stalls: load-use, or RAW / WAW / structural against a busy mc unit.
  // Flush kills the instruction, so it cancels these; mem_wait freezes anyway.
  assign w_haz_stall = id_valid &&
                       ((|w_load_use) ||
                        (w_busy && ((|w_mc_match) || id_is_mc ||
                                    (id_we && (id_dest != '0) &&
                                     (id_dest == r_mc_dest)))));
  assign stall   = mem_wait || (!flush && w_haz_stall);
  assign bubble  = !mem_wait && !flush && w_haz_stall;
  assign w_issue = id_valid && !stall && !flush;
  assign mc_busy = w_busy || w_done;
  assign mc_done = w_done;

  // Entry entering stage 1: the issued instruction, else a bubble. Mc ops
  // write back through the mc bus, not the stage tags.
  always_comb begin
    w_new = '0;
    if (w_issue && !id_is_mc) begin
      w_new.valid   = 1'b1;
      w_new.dest    = MAX_REG_AW'(id_dest);
      w_new.we      = id_we;
      w_new.is_load = id_is_load;
    end
  end

  // Tag pipeline shifts one stage per unfrozen cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < DEPTH; s++) r_stage[s] <= '0;
    end else if (!mem_wait) begin
      r_stage[0] <= w_new;
      for (int s = 1; s < DEPTH; s++) r_stage[s] <= r_stage[s-1];
    end
  end

  // Multi-cycle FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_mc_dest <= '0;
    end else begin
      r_state   <= w_state_nx;
      r_cnt     <= w_cnt_nx;
      r_mc_dest <= w_mc_dest_nx;
    end
  end

  // Multi-cycle FSM next state; everything holds while frozen.
  always_comb begin
    w_state_nx   = r_state;
    w_cnt_nx     = r_cnt;
    w_mc_dest_nx = r_mc_dest;
    if (!mem_wait) begin
      case (r_state)
        IDLE, DONE: begin
          if (w_issue && id_is_mc) begin
            w_state_nx   = BUSY;
            w_cnt_nx     = CNT_W'(MC_LAT - 1);
            w_mc_dest_nx = id_dest;
          end else begin
            w_state_nx = IDLE;
          end
        end
        BUSY: begin
          if (r_cnt <= CNT_W'(1)) begin
            w_state_nx = DONE;
            w_cnt_nx   = '0;
          end else begin
            w_cnt_nx = r_cnt - CNT_W'(1);
          end
        end
        default: w_state_nx = IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hazard_forward_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hazard_forward_unit
//  Purpose  : Self-checking bench for hazard_forward_unit (default params).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_forward_unit;

  typedef struct packed {
    logic       v;
    logic [4:0] s0;
    logic [4:0] s1;
    logic [1:0] used;
    logic [4:0] d;
    logic       we;
    logic       ld;
    logic       mc;
    logic       mw;
    logic       fl;
  } stim_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       id_valid = 1'b0;
  logic [9:0] id_src = '0;
  logic [1:0] id_src_used = '0;
  logic [4:0] id_dest = '0;
  logic       id_we = 1'b0, id_is_load = 1'b0, id_is_mc = 1'b0;
  logic       mem_wait = 1'b0, flush = 1'b0;
  logic       stall, bubble, mc_busy, mc_done;
  logic [5:0] fwd_sel;
  logic [1:0] hazard;
  logic [11:0] obs;

  int n_checks = 0;
  int n_errors = 0;
  logic [11:0] exp_q [$];

  hazard_forward_unit dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_src(id_src),
    .id_src_used(id_src_used), .id_dest(id_dest), .id_we(id_we),
    .id_is_load(id_is_load), .id_is_mc(id_is_mc), .mem_wait(mem_wait),
    .flush(flush), .stall(stall), .bubble(bubble), .fwd_sel(fwd_sel),
    .hazard(hazard), .mc_busy(mc_busy), .mc_done(mc_done)
  );

  always #5 clk = ~clk;

  // Fields: stall, bubble, fwd_sel[1], fwd_sel[0], hazard[1:0], mc_busy, mc_done
  assign obs = {stall, bubble, fwd_sel, hazard, mc_busy, mc_done};

  function automatic stim_t st(input logic v, input logic [4:0] s0, input logic [4:0] s1,
                               input logic [1:0] used, input logic [4:0] d, input logic we,
                               input logic ld, input logic mc, input logic mw, input logic fl);
    stim_t x;
    x = '{v, s0, s1, used, d, we, ld, mc, mw, fl};
    return x;
  endfunction

  // Expected output vector; hazard flags derive from the selects.
  function automatic logic [11:0] ev(input logic sl, input logic bu, input logic [2:0] f1,
                                     input logic [2:0] f0, input logic busy, input logic done);
    return {sl, bu, f1, f0, (f1 != 3'd0), (f0 != 3'd0), busy, done};
  endfunction

  task automatic apply(input stim_t x);
    id_valid    = x.v;
    id_src      = {x.s1, x.s0};
    id_src_used = x.used;
    id_dest     = x.d;
    id_we       = x.we;
    id_is_load  = x.ld;
    id_is_mc    = x.mc;
    mem_wait    = x.mw;
    flush       = x.fl;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    apply(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [11:0] got, want;
    rst_n = 1'b0;
    apply(st(1, 1, 2, 2'b11, 3, 1, 1, 1, 0, 0));
    exp_q.push_back(ev(0, 0, 0, 0, 0, 0));
    @(negedge clk);
    got = obs; want = exp_q.pop_front(); n_checks++;
    if (got !== want) begin
      n_errors++; $display("FAIL reset_hold: got %h required %h", got, want);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    exp_q.push_back(ev(0, 0, 0, 0, 0, 0));
    @(negedge clk);
    got = obs; want = exp_q.pop_front(); n_checks++;
    if (got !== want) begin
      n_errors++; $display("FAIL reset_release: got %h required %h", got, want);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    stim_t s [7];
    logic [11:0] e [7];
    logic [11:0] got, want;
    do_reset();
    s[0] = st(1, 1, 2, 2'b11, 3, 1, 0, 0, 0, 0); e[0] = ev(0, 0, 0, 0, 0, 0);
    s[1] = st(1, 3, 5, 2'b11, 4, 1, 0, 0, 0, 0); e[1] = ev(0, 0, 0, 1, 0, 0);
    s[2] = st(1, 1, 2, 2'b11, 6, 1, 0, 0, 0, 0); e[2] = ev(0, 0, 0, 0, 0, 0);
    s[3] = st(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0); e[3] = ev(0, 0, 0, 0, 0, 0);
    s[4] = st(1, 6, 4, 2'b11, 7, 1, 0, 0, 0, 0); e[4] = ev(0, 0, 3, 2, 0, 0);
    s[5] = st(1, 1, 1, 2'b00, 7, 1, 0, 0, 0, 0); e[5] = ev(0, 0, 0, 0, 0, 0);
    s[6] = st(1, 7, 7, 2'b01, 8, 1, 0, 0, 0, 0); e[6] = ev(0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 7; i++) begin
      apply(s[i]); exp_q.push_back(e[i]);
      @(negedge clk);
      got = obs; want = exp_q.pop_front(); n_checks++;
      if (got !== want) begin
        n_errors++; $display("FAIL back_to_back[%0d]: got %h required %h", i, got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_use();
    stim_t s [6];
    logic [11:0] e [6];
    logic [11:0] got, want;
    do_reset();
    s[0] = st(1, 1, 0, 2'b01, 8, 1, 1, 0, 0, 0);  e[0] = ev(0, 0, 0, 0, 0, 0);
    s[1] = st(1, 8, 8, 2'b11, 9, 1, 0, 0, 0, 0);  e[1] = ev(1, 1, 1, 1, 0, 0);
    s[2] = st(1, 8, 8, 2'b11, 9, 1, 0, 0, 0, 0);  e[2] = ev(0, 0, 2, 2, 0, 0);
    s[3] = st(1, 0, 0, 2'b00, 11, 1, 1, 0, 0, 0); e[3] = ev(0, 0, 0, 0, 0, 0);
    s[4] = st(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);  e[4] = ev(0, 0, 0, 0, 0, 0);
    s[5] = st(1, 11, 9, 2'b11, 12, 1, 0, 0, 0, 0); e[5] = ev(0, 0, 3, 2, 0, 0);
    for (int i = 0; i < 6; i++) begin
      apply(s[i]); exp_q.push_back(e[i]);
      @(negedge clk);
      got = obs; want = exp_q.pop_front(); n_checks++;
      if (got !== want) begin
        n_errors++; $display("FAIL load_use[%0d]: got %h required %h", i, got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_zero_reg();
    stim_t s [2];
    logic [11:0] e [2];
    logic [11:0] got, want;
    do_reset();
    s[0] = st(1, 1, 2, 2'b11, 0, 1, 1, 0, 0, 0); e[0] = ev(0, 0, 0, 0, 0, 0);
    s[1] = st(1, 0, 0, 2'b11, 5, 1, 0, 0, 0, 0); e[1] = ev(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      apply(s[i]); exp_q.push_back(e[i]);
      @(negedge clk);
      got = obs; want = exp_q.pop_front(); n_checks++;
      if (got !== want) begin
        n_errors++; $display("FAIL zero_reg[%0d]: got %h required %h", i, got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_multicycle();
    stim_t s [11];
    logic [11:0] e [11];
    logic [11:0] got, want;
    do_reset();
    s[0]  = st(1, 1, 2, 2'b11, 10, 1, 0, 1, 0, 0); e[0]  = ev(0, 0, 0, 0, 0, 0);
    s[1]  = st(1, 10, 1, 2'b11, 13, 1, 0, 0, 0, 0); e[1]  = ev(1, 1, 0, 0, 1, 0);
    s[2]  = s[1];                                   e[2]  = ev(1, 1, 0, 0, 1, 0);
    s[3]  = s[1];                                   e[3]  = ev(1, 1, 0, 0, 1, 0);
    s[4]  = s[1];                                   e[4]  = ev(0, 0, 0, 4, 1, 1);
    s[5]  = st(1, 1, 2, 2'b11, 14, 1, 0, 1, 0, 0); e[5]  = ev(0, 0, 0, 0, 0, 0);
    s[6]  = st(1, 3, 4, 2'b11, 15, 1, 0, 1, 0, 0); e[6]  = ev(1, 1, 0, 0, 1, 0);
    s[7]  = st(1, 1, 2, 2'b11, 14, 1, 0, 0, 0, 0); e[7]  = ev(1, 1, 0, 0, 1, 0);
    s[8]  = st(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);  e[8]  = ev(0, 0, 0, 0, 1, 0);
    s[9]  = st(1, 3, 4, 2'b11, 15, 1, 0, 1, 0, 0); e[9]  = ev(0, 0, 0, 0, 1, 1);
    s[10] = st(1, 15, 0, 2'b01, 16, 1, 0, 0, 0, 0); e[10] = ev(1, 1, 0, 0, 1, 0);
    for (int i = 0; i < 11; i++) begin
      apply(s[i]); exp_q.push_back(e[i]);
      @(negedge clk);
      got = obs; want = exp_q.pop_front(); n_checks++;
      if (got !== want) begin
        n_errors++; $display("FAIL multicycle[%0d]: got %h required %h", i, got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_mem_wait();
    stim_t s [5];
    logic [11:0] e [5];
    logic [11:0] got, want;
    do_reset();
    s[0] = st(1, 1, 0, 2'b01, 8, 1, 1, 0, 0, 0); e[0] = ev(0, 0, 0, 0, 0, 0);
    s[1] = st(1, 8, 8, 2'b11, 9, 1, 0, 0, 1, 0); e[1] = ev(1, 0, 1, 1, 0, 0);
    s[2] = s[1];                                 e[2] = ev(1, 0, 1, 1, 0, 0);
    s[3] = st(1, 8, 8, 2'b11, 9, 1, 0, 0, 0, 0); e[3] = ev(1, 1, 1, 1, 0, 0);
    s[4] = s[3];                                 e[4] = ev(0, 0, 2, 2, 0, 0);
    for (int i = 0; i < 5; i++) begin
      apply(s[i]); exp_q.push_back(e[i]);
      @(negedge clk);
      got = obs; want = exp_q.pop_front(); n_checks++;
      if (got !== want) begin
        n_errors++; $display("FAIL mem_wait[%0d]: got %h required %h", i, got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_flush();
    stim_t s [4];
    logic [11:0] e [4];
    logic [11:0] got, want;
    do_reset();
    s[0] = st(1, 1, 0, 2'b01, 8, 1, 1, 0, 0, 0); e[0] = ev(0, 0, 0, 0, 0, 0);
    s[1] = st(1, 8, 8, 2'b11, 9, 1, 0, 0, 0, 1); e[1] = ev(0, 0, 1, 1, 0, 0);
    s[2] = st(1, 8, 9, 2'b11, 9, 1, 0, 0, 0, 0); e[2] = ev(0, 0, 0, 2, 0, 0);
    s[3] = st(1, 8, 9, 2'b11, 9, 1, 0, 0, 1, 1); e[3] = ev(1, 0, 1, 3, 0, 0);
    for (int i = 0; i < 4; i++) begin
      apply(s[i]); exp_q.push_back(e[i]);
      @(negedge clk);
      got = obs; want = exp_q.pop_front(); n_checks++;
      if (got !== want) begin
        n_errors++; $display("FAIL flush[%0d]: got %h required %h", i, got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_busy();
    logic [11:0] got, want;
    do_reset();
    apply(st(1, 1, 2, 2'b11, 10, 1, 0, 1, 0, 0));
    @(posedge clk); #1;
    apply(st(1, 10, 1, 2'b11, 13, 1, 0, 0, 0, 0));
    exp_q.push_back(ev(1, 1, 0, 0, 1, 0));
    @(negedge clk);
    got = obs; want = exp_q.pop_front(); n_checks++;
    if (got !== want) begin
      n_errors++; $display("FAIL busy_before_reset: got %h required %h", got, want);
    end
    exp_q.push_back(ev(0, 0, 0, 0, 0, 0));
    #1 rst_n = 1'b0;
    #1;
    got = obs; want = exp_q.pop_front(); n_checks++;
    if (got !== want) begin
      n_errors++; $display("FAIL async_reset_busy: got %h required %h", got, want);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    exp_q.push_back(ev(0, 0, 0, 0, 0, 0));
    @(negedge clk);
    got = obs; want = exp_q.pop_front(); n_checks++;
    if (got !== want) begin
      n_errors++; $display("FAIL after_reset_busy: got %h required %h", got, want);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_back_to_back();
    test_load_use();
    test_zero_reg();
    test_multicycle();
    test_mem_wait();
    test_flush();
    test_reset_busy();
    if (exp_q.size() != 0) begin
      n_checks++; n_errors++;
      $display("FAIL scoreboard_drain: %0d left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hazard_forward_unit.md
Name: hazard_forward_unit

Overview:
- Parametrised pipeline hazard unit for the MIPS core. It sits beside decode (ID) and replaces purely combinational "hazard flag" detection.
- It keeps a registered tag pipeline of in-flight destination registers and produces per-source forwarding selects.
- It generates load-use and multi-cycle (mul/div) stalls through a small busy FSM.

Parameters:
- REG_AW, 5, register address width.
- NUM_SRC, 2, number of source operands checked per decoded instruction.
- DEPTH, 3, number of tracked stages after ID (stage 1 = EX, 2 = MEM, 3 = WB).
- LOAD_READY, 2, first stage at which a load result can be forwarded.
- MC_LAT, 4, multi-cycle unit latency in cycles; must be >= 2.
- SEL_W, derived as $clog2(DEPTH+2), width of one forwarding select.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  decode slot holds a real instruction.
- id_src  in  NUM_SRC*REG_AW  source register addresses; source i occupies bits [i*REG_AW +: REG_AW].
- id_src_used  in  NUM_SRC  per-source "operand actually read" mask.
- id_dest  in  REG_AW  destination register.
- id_we  in  1  instruction writes id_dest.
- id_is_load  in  1  instruction is a load.
- id_is_mc  in  1  instruction issues to the multi-cycle unit.
- mem_wait  in  1  external freeze; the whole pipeline holds.
- flush  in  1  kill the ID instruction and stage 1.
- stall  out  1  hold PC and the IF/ID register.
- bubble  out  1  insert a NOP into EX this cycle.
- fwd_sel  out  NUM_SRC*SEL_W  per-source operand select: 0 = regfile, k = stage k result (1..DEPTH), DEPTH+1 = multi-cycle result bus.
- hazard  out  NUM_SRC  per-source "operand forwarded" flag, set when fwd_sel != 0.
- mc_busy  out  1  multi-cycle unit occupied.
- mc_done  out  1  multi-cycle result valid this cycle.

Behaviour:
- Reset (asynchronous, rst_n=0): all stage entries invalid, FSM in IDLE, counter 0. Outputs go to stall=0, bubble=0, fwd_sel=0, hazard=0, mc_busy=0, mc_done=0.
- Stage entry fields: valid, dest, we, is_load.
- Issue: a live ID instruction issues when id_valid && !stall && !flush. Non-mc instructions load stage 1; mc instructions load stage 1 as a bubble (we=0).
- Normal advance (no mem_wait): each stage s copies stage s-1. Stage 1 gets the issued instruction, or a bubble when stall, flush or !id_valid. The entry in stage DEPTH retires.
- mem_wait=1:
  - Tags and the FSM counter hold.
  - stall=1 and bubble=0.
  - fwd_sel is still computed against the held tags.
- Register 0 never matches anything.
- Source i matches stage s when: id_src_used[i], stage s valid, stage s we, and stage dest == id_src[i].
- Forward priority: the youngest (lowest s) matching stage wins, then fwd_sel[i] = s. With no match, fwd_sel[i] = 0.
- Load-use stall: the winning stage is a load with s < LOAD_READY. The result is stall=1 and bubble=1.
- Multi-cycle FSM:
  - IDLE: an issuing mc instruction latches mc_dest and loads cnt = MC_LAT-1, then goes to BUSY.
  - BUSY: cnt decrements each non-frozen cycle. When cnt reaches 0, go to DONE.
  - DONE: one cycle with mc_done=1, then return to IDLE. If an mc instruction issues in the same cycle, go straight back to BUSY.
  - mc_busy=1 in BUSY and in DONE.
- MC stall conditions (all give stall=1, bubble=1):
  - In BUSY, any used source equals mc_dest (RAW).
  - In BUSY, an id_we destination equals mc_dest (WAW).
  - In BUSY, a new id_is_mc arrives (structural).
- MC forwarding: in DONE, a source matching mc_dest with no younger stage match gets fwd_sel = DEPTH+1. A stage match takes priority over the MC bus.
- Flush: the ID instruction does not issue and stage 1 becomes invalid on the next edge. Stages 2..DEPTH and the MC FSM are unaffected. Flush outranks stall: bubble=0 and stall=0 unless mem_wait.
- Timing: all outputs are combinational from registered state plus ID inputs. Tag update latency is 1 cycle.

Decomposition:
- Shared package hazard_pkg holds:
  - FSM state enum: IDLE, BUSY, DONE.
  - The stage-entry struct.
  - Select codes: SEL_RF=0 and SEL_MC=DEPTH+1.
- One sub-module, hazard_src_match, instantiated NUM_SRC times. It computes one source's priority match against all stages and returns its fwd_sel and load-use flag.

Test Plan:
- Back-to-back ALU, add $3 then sub $4,$3,$5: cycle 2 gives fwd_sel[0]=1, hazard=01, no stall. With one gap in between, fwd_sel[0]=2.
- Load-use, lw $8 then add $9,$8,$8: one cycle of stall=1 and bubble=1, then fwd_sel=2 for both sources. With one gap in between, there is no stall.
- Source $0 with a stage holding dest $0 and we=1: fwd_sel=0, hazard=0.
- mult to $10 with MC_LAT=4, then a dependent instruction on $10: stall held for 3 cycles in BUSY, then DONE gives mc_done=1, fwd_sel=4, stall=0. A second mc instruction issued during BUSY stalls.
- mem_wait asserted for 2 cycles while a load sits in stage 1: tags freeze, stall=1, bubble=0. On release, the load-use stall resolves after one bubble.
- Flush together with a load-use condition: stall=0, stage 1 invalid next cycle. Asserting rst_n=0 mid-BUSY returns all outputs to 0 immediately.
